// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the FE-side gshare/BTB predictor and the
// FE<->AGEX prediction/resolution bundles.
package branch_predictor_pkg;

  localparam int unsigned DBITS_DEF        = 32;
  localparam int unsigned BHR_BITS_DEF     = 8;
  localparam int unsigned BTB_IDX_BITS_DEF = 4;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  // from_FE_to_AGEX prediction info, packed {pred_taken, pred_target, pred_bhr}
  localparam int unsigned FE_PRED_BHR_LSB    = 0;
  localparam int unsigned FE_PRED_BHR_MSB    = BHR_BITS_DEF - 1;
  localparam int unsigned FE_PRED_TARGET_LSB = BHR_BITS_DEF;
  localparam int unsigned FE_PRED_TARGET_MSB = BHR_BITS_DEF + DBITS_DEF - 1;
  localparam int unsigned FE_PRED_TAKEN_BIT  = BHR_BITS_DEF + DBITS_DEF;
  localparam int unsigned FROM_FE_TO_AGEX_PRED_WIDTH = 1 + DBITS_DEF + BHR_BITS_DEF;

  // Resolution bundle, packed in port order:
  // {upd_valid, upd_pc, upd_cond, upd_taken, upd_target, upd_bhr, upd_mispredict}
  localparam int unsigned BHR_FROM_AGEX_TO_FE_WIDTH =
    1 + DBITS_DEF + 1 + 1 + DBITS_DEF + BHR_BITS_DEF + 1;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != CTR_ST) nxt = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predictor_btb_dm.sv
// Direct-mapped branch target buffer: combinational tag-compare read port
// and one synchronous write port; the read sees pre-write contents.
module btb_dm
  import branch_predictor_pkg::*;
#(
  parameter int unsigned DBITS    = DBITS_DEF,
  parameter int unsigned IDX_BITS = BTB_IDX_BITS_DEF
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [DBITS-1:0] rd_pc_i,
  output logic             rd_hit_o,
  output logic             rd_is_cond_o,
  output logic [DBITS-1:0] rd_target_o,
  input  logic             wr_en_i,
  input  logic [DBITS-1:0] wr_pc_i,
  input  logic             wr_is_cond_i,
  input  logic [DBITS-1:0] wr_target_i
);

  localparam int unsigned ENTRIES  = 1 << IDX_BITS;
  localparam int unsigned TAG_BITS = DBITS - IDX_BITS - 2;

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic                is_cond_q[ENTRIES];
  logic [DBITS-1:0]    target_q [ENTRIES];

  logic [IDX_BITS-1:0] rd_idx, wr_idx;
  logic [TAG_BITS-1:0] rd_tag, wr_tag;
  logic                unused_pc_lsbs;

  assign rd_idx = rd_pc_i[IDX_BITS+1:2];
  assign rd_tag = rd_pc_i[DBITS-1:IDX_BITS+2];
  assign wr_idx = wr_pc_i[IDX_BITS+1:2];
  assign wr_tag = wr_pc_i[DBITS-1:IDX_BITS+2];

  assign unused_pc_lsbs = ^{rd_pc_i[1:0], wr_pc_i[1:0]};

  assign rd_hit_o     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_is_cond_o = is_cond_q[rd_idx];
  assign rd_target_o  = target_q[rd_idx];

  // Only valid bits need clearing; payload is don't-care until written.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && wr_en_i) begin
      tag_q[wr_idx]     <= wr_tag;
      is_cond_q[wr_idx] <= wr_is_cond_i;
      target_q[wr_idx]  <= wr_target_i;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Gshare direction predictor with a direct-mapped BTB for FE next-PC
// selection; trained non-speculatively by AGEX resolutions.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned DBITS        = DBITS_DEF,
  parameter int unsigned BHR_BITS     = BHR_BITS_DEF,
  parameter int unsigned BTB_IDX_BITS = BTB_IDX_BITS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DBITS-1:0]    pred_pc,
  output logic                pred_taken,
  output logic [DBITS-1:0]    pred_target,
  output logic [BHR_BITS-1:0] pred_bhr,
  input  logic                upd_valid,
  input  logic [DBITS-1:0]    upd_pc,
  input  logic                upd_cond,
  input  logic                upd_taken,
  input  logic [DBITS-1:0]    upd_target,
  input  logic [BHR_BITS-1:0] upd_bhr,
  input  logic                upd_mispredict,
  output logic [BHR_BITS-1:0] bhr_out,
  output logic [DBITS-1:0]    mispred_count
);

  localparam int unsigned PHT_ENTRIES = 1 << BHR_BITS;

  logic [1:0]          pht_q [PHT_ENTRIES];
  logic [BHR_BITS-1:0] bhr_q, bhr_d;
  logic [DBITS-1:0]    mispred_q, mispred_d;

  logic                upd_en;
  logic [BHR_BITS-1:0] pred_idx, upd_idx;
  logic                pht_we;
  logic [1:0]          pht_wdata;
  logic [DBITS-1:0]    pc_plus4;
  logic                btb_hit, btb_is_cond;
  logic [DBITS-1:0]    btb_target;

  assign upd_en   = upd_valid && !reset;
  assign pred_idx = pred_pc[BHR_BITS+1:2] ^ bhr_q;
  assign upd_idx  = upd_pc[BHR_BITS+1:2] ^ upd_bhr;
  assign pc_plus4 = pred_pc + DBITS'(4);

  btb_dm #(
    .DBITS    (DBITS),
    .IDX_BITS (BTB_IDX_BITS)
  ) u_btb (
    .clk_i        (clk),
    .reset_i      (reset),
    .rd_pc_i      (pred_pc),
    .rd_hit_o     (btb_hit),
    .rd_is_cond_o (btb_is_cond),
    .rd_target_o  (btb_target),
    .wr_en_i      (upd_en && upd_taken),
    .wr_pc_i      (upd_pc),
    .wr_is_cond_i (upd_cond),
    .wr_target_i  (upd_target)
  );

  // Prediction is forced to fall-through while reset is held.
  always_comb begin
    pred_taken  = 1'b0;
    pred_target = pc_plus4;
    pred_bhr    = '0;
    if (!reset) begin
      pred_bhr = bhr_q;
      if (btb_hit && (!btb_is_cond || pht_q[pred_idx][1])) begin
        pred_taken  = 1'b1;
        pred_target = btb_target;
      end
    end
  end

  always_comb begin
    bhr_d     = bhr_q;
    mispred_d = mispred_q;
    pht_we    = 1'b0;
    pht_wdata = ctr_next(pht_q[upd_idx], upd_taken);
    if (upd_en) begin
      if (upd_cond) begin
        pht_we = 1'b1;
        bhr_d  = {bhr_q[BHR_BITS-2:0], upd_taken};
      end
      if (upd_mispredict) mispred_d = mispred_q + DBITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bhr_q     <= '0;
      mispred_q <= '0;
    end else begin
      bhr_q     <= bhr_d;
      mispred_q <= mispred_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pht_q <= '{default: CTR_WNT};
    end else if (pht_we) begin
      pht_q[upd_idx] <= pht_wdata;
    end
  end

  assign bhr_out       = bhr_q;
  assign mispred_count = mispred_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed plus randomized checking of branch_predictor against a
// table-level reference model of the gshare/BTB rules.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [7:0]  pred_bhr;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_cond;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [7:0]  upd_bhr;
  logic        upd_mispredict;
  logic [7:0]  bhr_out;
  logic [31:0] mispred_count;

  int vectors = 0;
  int miscompares = 0;

  // Reference state
  int unsigned m_pht [256];
  bit          m_bv  [16];
  int unsigned m_tag [16];
  bit          m_cond[16];
  logic [31:0] m_tgt [16];
  int unsigned m_bhr;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  branch_predictor #(
    .DBITS        (32),
    .BHR_BITS     (8),
    .BTB_IDX_BITS (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pred_pc        (pred_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .pred_bhr       (pred_bhr),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_cond       (upd_cond),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_bhr        (upd_bhr),
    .upd_mispredict (upd_mispredict),
    .bhr_out        (bhr_out),
    .mispred_count  (mispred_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void m_clear();
    for (int i = 0; i < 256; i++) m_pht[i] = 1;
    for (int i = 0; i < 16; i++) m_bv[i] = 1'b0;
    m_bhr = 0;
    m_cnt = 32'd0;
  endfunction

  function automatic void m_predict(input logic rst, input logic [31:0] pc,
                                    output logic tk, output logic [31:0] tg,
                                    output logic [7:0] bh);
    int unsigned pi, bi;
    tk = 1'b0;
    tg = pc + 32'd4;
    bh = 8'd0;
    if (!rst) begin
      bh = 8'(m_bhr);
      pi = ((pc / 4) % 256) ^ m_bhr;
      bi = (pc / 4) % 16;
      if (m_bv[bi] && m_tag[bi] == pc / 64 && (!m_cond[bi] || m_pht[pi] >= 2)) begin
        tk = 1'b1;
        tg = m_tgt[bi];
      end
    end
  endfunction

  function automatic void m_update();
    int unsigned pi, bi;
    if (reset) begin
      m_clear();
    end else if (upd_valid) begin
      if (upd_cond) begin
        pi = ((upd_pc / 4) % 256) ^ 32'(upd_bhr);
        if (upd_taken) m_pht[pi] = (m_pht[pi] == 3) ? 3 : m_pht[pi] + 1;
        else           m_pht[pi] = (m_pht[pi] == 0) ? 0 : m_pht[pi] - 1;
        m_bhr = (m_bhr * 2 + 32'(upd_taken)) % 256;
      end
      if (upd_taken) begin
        bi = (upd_pc / 4) % 16;
        m_bv[bi]   = 1'b1;
        m_tag[bi]  = upd_pc / 64;
        m_cond[bi] = upd_cond;
        m_tgt[bi]  = upd_target;
      end
      if (upd_mispredict) m_cnt = m_cnt + 32'd1;
    end
  endfunction

  task automatic drive(input logic [31:0] ppc, input logic uv, input logic [31:0] upc,
                       input logic uc, input logic ut, input logic [31:0] utg,
                       input logic [7:0] ub, input logic um);
    pred_pc        = ppc;
    upd_valid      = uv;
    upd_pc         = upc;
    upd_cond       = uc;
    upd_taken      = ut;
    upd_target     = utg;
    upd_bhr        = ub;
    upd_mispredict = um;
  endtask

  // Compare all outputs against the model, then clock and advance the model.
  task automatic cycle();
    logic       tk;
    logic [31:0] tg;
    logic [7:0] bh;
    #2;
    m_predict(reset, pred_pc, tk, tg, bh);
    chk("pred_taken",    32'(pred_taken), 32'(tk));
    chk("pred_target",   pred_target, tg);
    chk("pred_bhr",      32'(pred_bhr), 32'(bh));
    chk("bhr_out",       32'(bhr_out), m_bhr);
    chk("mispred_count", mispred_count, m_cnt);
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  task automatic upd(input logic [31:0] pc, input logic c, input logic t,
                     input logic [31:0] tg, input logic [7:0] b, input logic mp);
    drive(pc, 1'b1, pc, c, t, tg, b, mp);
    cycle();
  endtask

  task automatic query(input string tag, input logic [31:0] pc, input logic exp_tk,
                       input logic [31:0] exp_tg, input logic [7:0] exp_bhr,
                       input logic [31:0] exp_cnt);
    drive(pc, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 8'd0, 1'b0);
    #1;
    chk({tag, ".taken"},  32'(pred_taken), 32'(exp_tk));
    chk({tag, ".target"}, pred_target, exp_tg);
    chk({tag, ".bhr"},    32'(bhr_out), 32'(exp_bhr));
    chk({tag, ".count"},  mispred_count, exp_cnt);
    cycle();
  endtask

  initial begin
    logic [31:0] rpc, rupc;
    drive(32'h100, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 8'd0, 1'b0);
    reset = 1'b1;
    m_clear();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    query("reset", 32'h100, 1'b0, 32'h104, 8'h00, 32'd0);
    chk("reset.pred_bhr", 32'(pred_bhr), 32'd0);

    upd(32'h100, 1'b1, 1'b1, 32'h80, 8'h00, 1'b0);
    upd(32'h100, 1'b1, 1'b1, 32'h80, 8'h00, 1'b0);
    query("cond_hist03", 32'h100, 1'b0, 32'h104, 8'h03, 32'd0);

    upd(32'h100, 1'b1, 1'b1, 32'h80, 8'h01, 1'b0);
    upd(32'h100, 1'b1, 1'b1, 32'h80, 8'h01, 1'b0);
    for (int i = 0; i < 7; i++) upd(32'h304, 1'b1, 1'b0, 32'h700, 8'h00, 1'b0);
    upd(32'h304, 1'b1, 1'b1, 32'h700, 8'h00, 1'b0);
    query("cond_hist01", 32'h100, 1'b1, 32'h80, 8'h01, 32'd0);

    upd(32'h200, 1'b0, 1'b1, 32'h400, 8'h00, 1'b0);
    query("uncond", 32'h200, 1'b1, 32'h400, 8'h01, 32'd0);

    for (int i = 0; i < 5; i++) upd(32'h100, 1'b1, 1'b1, 32'h80, 8'h7E, 1'b0);
    upd(32'h100, 1'b1, 1'b0, 32'h80, 8'h7E, 1'b0);
    query("sat_ctr2", 32'h100, 1'b1, 32'h80, 8'h7E, 32'd0);

    for (int i = 0; i < 3; i++) upd(32'h100, 1'b1, 1'b0, 32'h80, 8'h7E, 1'b0);
    for (int i = 0; i < 8; i++)
      upd(32'h304, 1'b1, (i != 0 && i != 7), 32'h700, 8'h00, 1'b0);
    query("sat_ctr0", 32'h100, 1'b0, 32'h104, 8'h7E, 32'd0);

    upd(32'h100, 1'b0, 1'b1, 32'h80, 8'h00, 1'b0);
    drive(32'h100, 1'b1, 32'h140, 1'b0, 1'b1, 32'h500, 8'h00, 1'b0);
    #1;
    chk("bypass.taken",  32'(pred_taken), 32'd1);
    chk("bypass.target", pred_target, 32'h80);
    cycle();
    query("alias_miss", 32'h100, 1'b0, 32'h104, 8'h7E, 32'd0);
    query("alias_new",  32'h140, 1'b1, 32'h500, 8'h7E, 32'd0);

    for (int i = 0; i < 3; i++) upd(32'h600, 1'b0, 1'b0, 32'h0, 8'h00, 1'b1);
    query("mispred3", 32'h600, 1'b0, 32'h604, 8'h7E, 32'd3);

    reset = 1'b1;
    upd(32'h140, 1'b1, 1'b1, 32'h900, 8'h00, 1'b1);
    reset = 1'b0;
    query("reset_midop", 32'h140, 1'b0, 32'h144, 8'h00, 32'd0);

    // Small PC pool so random traffic produces BTB hits, aliases and PHT reuse.
    for (int n = 0; n < 1500; n++) begin
      rpc  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2);
      rupc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2);
      if ($urandom_range(0, 15) == 0) rupc = $urandom & 32'hFFFF_FFFC;
      drive(rpc, ($urandom_range(0, 9) < 7), rupc, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
            ($urandom_range(0, 1) == 0) ? 8'(m_bhr) : 8'($urandom),
            ($urandom_range(0, 3) == 0));
      reset = ($urandom_range(0, 99) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
